// File: rtl/dense_controller.sv
// dense_controller: sequences the dense-layer datapath through clear, per-neuron MAC and bias-write phases.
module dense_controller #(
  parameter int IN_COUNT  = 64,
  parameter int OUT_COUNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic inValid,
  output logic inRelease,
  output logic outValid,
  input  logic outReady,
  output logic busy,
  input  logic mulDone,
  input  logic calcDone,
  output logic clear,
  output logic clearReg,
  output logic inCntEn,
  output logic outCntEn,
  output logic WorB,
  output logic load,
  output logic bufferOutWr
);
  typedef enum logic [2:0] {IDLE, INIT, MAC, BIAS, DONE} state_t;
  state_t state_q, state_d;
  if (IN_COUNT < 1 || OUT_COUNT < 1) begin : g_bad_cfg
    $error("dense_controller: IN_COUNT and OUT_COUNT must be at least 1");
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && inValid) ? INIT : IDLE;
      INIT:    state_d = MAC;
      MAC:     state_d = mulDone ? BIAS : MAC;
      BIAS:    state_d = calcDone ? DONE : MAC;
      DONE:    state_d = outReady ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state, so they are pure Moore decodes of state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      outValid    <= 1'b0;
      inRelease   <= 1'b0;
      bufferOutWr <= 1'b0;
      clear       <= 1'b0;
      clearReg    <= 1'b0;
      inCntEn     <= 1'b0;
      outCntEn    <= 1'b0;
      load        <= 1'b0;
      WorB        <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy        <= state_d != IDLE;
      outValid    <= state_d == DONE;
      inRelease   <= state_d == DONE && state_q != DONE;
      bufferOutWr <= state_d == BIAS;
      clear       <= state_d == INIT;
      clearReg    <= state_d == INIT || state_d == BIAS;
      inCntEn     <= state_d == MAC;
      outCntEn    <= state_d == BIAS;
      load        <= state_d == MAC;
      WorB        <= state_d == BIAS;
    end
  end
endmodule

// File: doc/dense_controller.md
# dense_controller

Sequencing FSM for the dense (fully connected) layer datapath. Drives the datapath's counter, accumulator and bias-select controls so each output neuron accumulates IN_COUNT products, then adds its bias and writes the result to the output buffer. Sits between the AXIS interface buffers (input-valid / output-ready handshakes) and the dense datapath, one instance per dense layer.

## Interface
- IN_COUNT, 64, inputs per neuron (≥1); used for cycle bookkeeping and the bench only; the datapath owns the counters.
- OUT_COUNT, 10, neurons in the layer (≥1).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset; FSM to IDLE.
- start  in  1  request one layer evaluation; sampled only in IDLE.
- inValid  in  1  input buffer holds a complete input vector.
- inRelease  out  1  one-cycle pulse: input buffer may be refilled.
- outValid  out  1  output buffer holds OUT_COUNT valid results; held until outReady.
- outReady  in  1  consumer has taken the output buffer.
- busy  out  1  high in every state except IDLE.
- mulDone  in  1  datapath input counter at IN_COUNT-1 (combinational carry-out).
- calcDone  in  1  datapath output counter at OUT_COUNT-1 (combinational carry-out).
- clear  out  1  synchronous clear of both datapath counters.
- clearReg  out  1  synchronous clear of the partial-sum register (priority over load).
- inCntEn  out  1  advance input counter.
- outCntEn  out  1  advance output counter.
- WorB  out  1  adder operand select: 0 = product, 1 = bias.
- load  out  1  partial-sum register load.
- bufferOutWr  out  1  write strobe for the output buffer at the datapath output address.

## Operation
- States: IDLE, INIT, MAC, BIAS, DONE. All outputs Moore-decoded from state, except the MAC→BIAS and BIAS→MAC/DONE decisions, which use mulDone/calcDone.
- IDLE: all outputs 0. start && inValid → INIT. start without inValid: stay, no response.
- INIT (1 cycle): clear=1, clearReg=1 → MAC.
- MAC: WorB=0, load=1, inCntEn=1; one product accumulated per cycle. mulDone=1 → BIAS (last product loaded on that edge; input counter wraps to 0).
- BIAS (1 cycle): WorB=1, load=0, bufferOutWr=1 (writes partialSum+bias at the current output index), clearReg=1, outCntEn=1. calcDone=0 → MAC; calcDone=1 → DONE (output counter wraps to 0).
- DONE: outValid=1. inRelease pulses on the first DONE cycle only. outReady=1 → IDLE. outReady is ignored outside DONE.
- start asserted while busy is ignored; a new run needs IDLE plus start.
- Arithmetic and widths belong to the datapath. The controller only guarantees clearReg before the first product of every neuron and exactly one bias add per neuron.

## Timing
- Reset: state IDLE. busy, outValid, inRelease, bufferOutWr, clear, clearReg, inCntEn, outCntEn, load and WorB are all 0 immediately (asynchronous).
- Reset mid-run aborts without a write. Datapath counters also reset. Output buffer contents are undefined and outValid stays 0.
- Run cycle count, from the start-accepting edge to the edge after which outValid=1: 1 + OUT_COUNT·(IN_COUNT+1).
- Exactly OUT_COUNT bufferOutWr pulses per run, one per neuron, to addresses 0..OUT_COUNT-1 in order.
- IN_COUNT=1: MAC lasts 1 cycle. OUT_COUNT=1: the first BIAS goes straight to DONE.
- outReady high on the first DONE cycle: DONE lasts 1 cycle, and the next start is accepted one cycle later from IDLE.
- Back-to-back runs: minimum gap of one IDLE cycle between runs.

## Test plan
- IN_COUNT=4, OUT_COUNT=3 with the datapath, inputs all 1, weights all 2, biases 3 → buffer = {11,11,11}, outValid rises 16 cycles after start, 3 write pulses.
- Weights w[i][j]=i+j, inputs x=i+1, bias=j → neuron j = Σ(i+1)(i+j)+j matches the model; write addresses 0,1,2 in order.
- Reset asserted in the 2nd neuron's MAC → all outputs 0 asynchronously, IDLE. A restart yields correct results with no stale accumulation.
- start with inValid=0 for 5 cycles → no state change. Then inValid=1 → INIT next edge; start pulses during the run are ignored.
- outReady held 0 for 10 cycles in DONE → outValid held and inRelease pulses exactly once. outReady=1 → IDLE next edge.
- IN_COUNT=1, OUT_COUNT=1 → run length 3 cycles, single write of x·w+b.
